// File: rtl/life_painter_if.sv
// Cell result stream in, framebuffer write port out; slave side is the painter,
// master side is the engine/framebuffer environment.
interface life_painter_if #(
  parameter int CORDW    = 16,
  parameter int FB_ADDRW = 15,
  parameter int COLRW    = 4
);
  logic                       cell_ready;
  logic                       cell_alive;
  logic                       cell_changed;
  logic signed [CORDW-1:0]    cell_x;
  logic signed [CORDW-1:0]    cell_y;
  logic                       gen_done;
  logic                       fb_busy;
  logic                       fb_we;
  logic        [FB_ADDRW-1:0] fb_addr;
  logic        [COLRW-1:0]    fb_colr;

  modport master (
    output cell_ready, cell_alive, cell_changed, cell_x, cell_y, gen_done, fb_busy,
    input  fb_we, fb_addr, fb_colr
  );

  modport slave (
    input  cell_ready, cell_alive, cell_changed, cell_x, cell_y, gen_done, fb_busy,
    output fb_we, fb_addr, fb_colr
  );
endinterface

// File: rtl/life_painter.sv
// Paints life-engine cell results as CELL_SIZE x CELL_SIZE pixel blocks through a small FIFO.
// Optional LIFE_PAINTER_CHANGED_ONLY_EN: only cells flagged as changed are painted.
module life_painter #(
  parameter int               CORDW      = 16,
  parameter int               CELL_SIZE  = 4,
  parameter int               FB_WIDTH   = 160,
  parameter int               FB_HEIGHT  = 120,
  parameter int               FB_ADDRW   = 15,
  parameter int               COLRW      = 4,
  parameter logic [COLRW-1:0] COLR_ALIVE = COLRW'(4'hF),
  parameter logic [COLRW-1:0] COLR_DEAD  = COLRW'(4'h0),
  parameter int               FIFO_DEPTH = 8,
  parameter int               POPW       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  life_painter_if.slave   bus,
  output logic            busy,
  output logic            gen_painted,
  output logic            overflow,
  output logic [POPW-1:0] population
);

  localparam int COLS = FB_WIDTH / CELL_SIZE;
  localparam int ROWS = FB_HEIGHT / CELL_SIZE;
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] PAINT = 2'd2;

  localparam logic [FB_ADDRW-1:0] ROW_STRIDE = FB_ADDRW'(CELL_SIZE * FB_WIDTH);
  localparam logic [FB_ADDRW-1:0] CS_A       = FB_ADDRW'(CELL_SIZE);
  localparam logic [FB_ADDRW-1:0] W_A        = FB_ADDRW'(FB_WIDTH);
  localparam logic [4:0]          LAST       = 5'(CELL_SIZE - 1);

  function automatic logic [POPW-1:0] sat_inc(input logic [POPW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic in_range(input logic signed [CORDW-1:0] x,
                                    input logic signed [CORDW-1:0] y);
    return (int'(x) >= 0) && (int'(x) < COLS) && (int'(y) >= 0) && (int'(y) < ROWS);
  endfunction

  // Stage p0: register the engine strobe stream
  logic                    vld_p0, gen_done_p0, alive_p0;
  logic signed [CORDW-1:0] x_p0, y_p0;
`ifdef LIFE_PAINTER_CHANGED_ONLY_EN
  logic                    changed_p0;
`else
  logic                    unused_changed;
  assign unused_changed = bus.cell_changed;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0      <= 1'b0;
      gen_done_p0 <= 1'b0;
    end else begin
      vld_p0      <= bus.cell_ready;
      gen_done_p0 <= bus.gen_done;
    end
  end

  always_ff @(posedge clk) begin
    alive_p0   <= bus.cell_alive;
    x_p0       <= bus.cell_x;
    y_p0       <= bus.cell_y;
`ifdef LIFE_PAINTER_CHANGED_ONLY_EN
    changed_p0 <= bus.cell_changed;
`endif
  end

  // Stage p1: FIFO and painter FSM
  logic                    mem_alive [FIFO_DEPTH];
  logic signed [CORDW-1:0] mem_x     [FIFO_DEPTH];
  logic signed [CORDW-1:0] mem_y     [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count, count_next;
  logic                    empty, full, push_req, push, pop;

  logic [1:0]              state, state_next;
  logic                    cur_alive;
  logic [FB_ADDRW-1:0]     cur_col, cur_row, base, base_calc;
  logic [4:0]              px, py, px_n, py_n;
  logic                    accept, last_px, fire, pending;
  logic [POPW-1:0]         pop_cnt, pop_cnt_inc;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));

`ifdef LIFE_PAINTER_CHANGED_ONLY_EN
  assign push_req = vld_p0 && changed_p0 && in_range(x_p0, y_p0);
`else
  assign push_req = vld_p0 && in_range(x_p0, y_p0);
`endif

  assign accept    = bus.fb_we && !bus.fb_busy;
  assign last_px   = (px == LAST) && (py == LAST);
  assign base_calc = cur_row * ROW_STRIDE + cur_col * CS_A;
  assign fire      = pending && empty && (state == IDLE);
  assign pop_cnt_inc = (vld_p0 && alive_p0) ? sat_inc(pop_cnt) : pop_cnt;

  always_comb begin
    px_n = px + 5'd1;
    py_n = py;
    if (px == LAST) begin
      px_n = 5'd0;
      py_n = py + 5'd1;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop        = 1'b1;
        state_next = LOAD;
      end
      LOAD: state_next = PAINT;
      PAINT: if (accept && last_px) begin
        pop        = !empty;
        state_next = empty ? IDLE : LOAD;
      end
      default: state_next = IDLE;
    endcase
    // A full FIFO still takes a push when the same cycle frees a slot
    push       = push_req && (!full || pop);
    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      px          <= '0;
      py          <= '0;
      bus.fb_we   <= 1'b0;
      bus.fb_addr <= '0;
      bus.fb_colr <= '0;
      busy        <= 1'b0;
      gen_painted <= 1'b0;
      pending     <= 1'b0;
      pop_cnt     <= '0;
      population  <= '0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      busy        <= (count_next != '0) || (state_next != IDLE);
      gen_painted <= fire;
      pending     <= (pending && !fire) || gen_done_p0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;

      if (gen_done_p0) begin
        population <= pop_cnt_inc;
        pop_cnt    <= '0;
      end else begin
        pop_cnt    <= pop_cnt_inc;
      end

      if (state == LOAD) begin
        px          <= '0;
        py          <= '0;
        bus.fb_we   <= 1'b1;
        bus.fb_addr <= base_calc;
        bus.fb_colr <= cur_alive ? COLR_ALIVE : COLR_DEAD;
      end else if (state == PAINT && accept) begin
        if (last_px) begin
          bus.fb_we   <= 1'b0;
        end else begin
          px          <= px_n;
          py          <= py_n;
          bus.fb_addr <= base + FB_ADDRW'(py_n) * W_A + FB_ADDRW'(px_n);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_alive[wr_ptr] <= alive_p0;
      mem_x[wr_ptr]     <= x_p0;
      mem_y[wr_ptr]     <= y_p0;
    end
    if (pop) begin
      cur_alive <= mem_alive[rd_ptr];
      cur_col   <= FB_ADDRW'(mem_x[rd_ptr]);
      cur_row   <= FB_ADDRW'(mem_y[rd_ptr]);
    end
    if (state == LOAD) base <= base_calc;
  end

endmodule

// File: tb/tb_life_painter.sv
// Bench for life_painter: table-driven single cells, corner sequences and randomized
// generations against a queue-based model of expected framebuffer writes.
module tb_life_painter;
  localparam int CORDW = 16, CELL_SIZE = 4, FB_WIDTH = 160, FB_HEIGHT = 120;
  localparam int FB_ADDRW = 15, COLRW = 4, FIFO_DEPTH = 8, POPW = 16;
  localparam int COLS = FB_WIDTH / CELL_SIZE, ROWS = FB_HEIGHT / CELL_SIZE;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            busy, gen_painted, overflow;
  logic [POPW-1:0] population;

  life_painter_if #(.CORDW(CORDW), .FB_ADDRW(FB_ADDRW), .COLRW(COLRW)) bus();

  life_painter #(
    .CORDW(CORDW), .CELL_SIZE(CELL_SIZE), .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT),
    .FB_ADDRW(FB_ADDRW), .COLRW(COLRW), .COLR_ALIVE(4'hF), .COLR_DEAD(4'h0),
    .FIFO_DEPTH(FIFO_DEPTH), .POPW(POPW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .gen_painted(gen_painted),
    .overflow(overflow), .population(population)
  );

  always #5 clk = ~clk;

  typedef struct { logic [FB_ADDRW-1:0] addr; logic [COLRW-1:0] colr; } wr_t;
  typedef struct { int x; int y; bit alive; int nwr; int first_addr; int colr; } vec_t;

  wr_t                 exp_q[$];
  int                  vectors = 0, miscompares = 0;
  int                  cyc = 0, wr_count = 0, last_wr_cyc = 0, gp_count = 0, gp_cyc = 0;
  bit                  hold_pend = 0, rnd_busy = 0;
  logic                busy_force = 1'b0;
  logic [FB_ADDRW-1:0] hold_addr;
  logic [COLRW-1:0]    hold_colr;

  task automatic check(input string name, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One cycle: drive fb_busy for the coming edge, then observe the write port
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    bus.fb_busy = rnd_busy ? ($urandom_range(0, 3) == 0) : busy_force;
    if (rst_n) begin
      if (hold_pend) begin
        check("hold_we", bus.fb_we, 1);
        check("hold_addr", bus.fb_addr, hold_addr);
        check("hold_colr", bus.fb_colr, hold_colr);
      end
      hold_pend = bus.fb_we && bus.fb_busy;
      hold_addr = bus.fb_addr;
      hold_colr = bus.fb_colr;
      if (bus.fb_we && !bus.fb_busy) begin
        wr_count++;
        last_wr_cyc = cyc;
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("write_addr", bus.fb_addr, e.addr);
          check("write_colr", bus.fb_colr, e.colr);
        end
      end
      if (gen_painted) begin
        gp_count++;
        gp_cyc = cyc;
        check("gp_queue_drained", exp_q.size(), 0);
        check("gp_no_write", bus.fb_we, 0);
      end
    end else begin
      hold_pend = 0;
    end
  endtask

  task automatic model_cell(input int x, input int y, input bit alive, input bit changed);
    wr_t w;
    bit  take;
    take = (x >= 0) && (x < COLS) && (y >= 0) && (y < ROWS);
`ifdef LIFE_PAINTER_CHANGED_ONLY_EN
    take = take && changed;
`else
    if (changed) take = take;
`endif
    if (take)
      for (int py = 0; py < CELL_SIZE; py++)
        for (int px = 0; px < CELL_SIZE; px++) begin
          w.addr = FB_ADDRW'((y * CELL_SIZE + py) * FB_WIDTH + x * CELL_SIZE + px);
          w.colr = alive ? 4'hF : 4'h0;
          exp_q.push_back(w);
        end
  endtask

  task automatic drive_cell(input int x, input int y, input bit alive, input bit changed,
                            input bit gd, input bit mdl);
    bus.cell_ready   = 1'b1;
    bus.cell_alive   = alive;
    bus.cell_changed = changed;
    bus.cell_x       = CORDW'(x);
    bus.cell_y       = CORDW'(y);
    bus.gen_done     = gd;
    if (mdl) model_cell(x, y, alive, changed);
    tick();
    bus.cell_ready = 1'b0;
    bus.gen_done   = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    tick();
    tick();
    while (busy && n < limit) begin
      tick();
      n++;
    end
    check({name, "_idle"}, busy, 0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_fb_we", bus.fb_we, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_population", population, 0);
    tick();
    tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   w0, w1, gp0, first, n, k, r, alive_cnt, ncell, x, y;
    logic [FB_ADDRW-1:0] fa;
    logic [COLRW-1:0]    fc;
    bit   live[36];
    bit   alv;

    tbl[0] = '{2, 1, 1'b1, 16, 648, 15};
    tbl[1] = '{0, 0, 1'b0, 16, 0, 0};
    tbl[2] = '{39, 29, 1'b1, 16, 18716, 15};
    tbl[3] = '{39, 0, 1'b0, 16, 156, 0};
    tbl[4] = '{-1, 0, 1'b1, 0, 0, 0};
    tbl[5] = '{40, 0, 1'b1, 0, 0, 0};
    tbl[6] = '{0, 30, 1'b1, 0, 0, 0};
    tbl[7] = '{3, -2, 1'b1, 0, 0, 0};

    bus.cell_ready = 0; bus.cell_alive = 0; bus.cell_changed = 0;
    bus.cell_x = '0; bus.cell_y = '0; bus.gen_done = 0; bus.fb_busy = 0;

    repeat (3) tick();
    check("reset_fb_we", bus.fb_we, 0);
    check("reset_fb_addr", bus.fb_addr, 0);
    check("reset_fb_colr", bus.fb_colr, 0);
    check("reset_busy", busy, 0);
    check("reset_gen_painted", gen_painted, 0);
    check("reset_overflow", overflow, 0);
    check("reset_population", population, 0);
    rst_n = 1'b1;
    tick();

    // Single cells: latency, first address/colour, write count, range filtering
    foreach (tbl[i]) begin
      w0 = wr_count;
      first = -1;
      fa = '0;
      fc = '0;
      drive_cell(tbl[i].x, tbl[i].y, tbl[i].alive, 1'b1, 1'b0, 1'b1);
      for (int t = 1; t <= 6; t++) begin
        tick();
        if (first < 0 && bus.fb_we) begin
          first = t;
          fa = bus.fb_addr;
          fc = bus.fb_colr;
        end
      end
      check("tbl_latency", first, (tbl[i].nwr > 0) ? 3 : -1);
      if (tbl[i].nwr > 0) begin
        check("tbl_first_addr", fa, tbl[i].first_addr);
        check("tbl_first_colr", fc, tbl[i].colr);
      end
      wait_idle(200, "tbl");
      check("tbl_nwrites", wr_count - w0, tbl[i].nwr);
      check("tbl_queue", exp_q.size(), 0);
      check("tbl_overflow", overflow, 0);
    end

    // Framebuffer stall of 5 cycles mid-block
    w0 = wr_count;
    drive_cell(2, 1, 1'b1, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (wr_count - w0 < 5 && n < 50) begin tick(); n++; end
    busy_force = 1'b1;
    repeat (5) tick();
    busy_force = 1'b0;
    wait_idle(200, "stall");
    check("stall_nwrites", wr_count - w0, 16);
    check("stall_queue", exp_q.size(), 0);

    // Reset in the middle of a block abandons it
    w0 = wr_count;
    drive_cell(5, 5, 1'b1, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (wr_count - w0 < 3 && n < 50) begin tick(); n++; end
    do_reset();
    w1 = wr_count;
    repeat (40) tick();
    check("after_reset_writes", wr_count - w1, 0);

    // 10 strobes against a stalled framebuffer: one cell is held by the painter,
    // FIFO_DEPTH more queue, the rest are dropped
    busy_force = 1'b1;
    repeat (2) tick();
    w0 = wr_count;
    for (int i = 0; i < 10; i++)
      drive_cell(i, 0, i[0], 1'b1, 1'b0, i < FIFO_DEPTH + 1);
    repeat (2) tick();
    check("ovf_set", overflow, 1);
    busy_force = 1'b0;
    wait_idle(1000, "ovf");
    check("ovf_nwrites", wr_count - w0, (FIFO_DEPTH + 1) * 16);
    check("ovf_sticky", overflow, 1);
    check("ovf_queue", exp_q.size(), 0);
    do_reset();
    tick();
    check("ovf_cleared", overflow, 0);

    // 6x6 generation, 5 live cells, gen_done on the last strobe
    foreach (live[i]) live[i] = 0;
    k = 0;
    while (k < 5) begin
      r = $urandom_range(0, 35);
      if (!live[r]) begin live[r] = 1; k++; end
    end
    gp0 = gp_count;
    for (int i = 0; i < 36; i++) begin
      drive_cell(i % 6, i / 6, live[i], 1'b1, i == 35, 1'b1);
      repeat (18) tick();
    end
    wait_idle(500, "gen");
    check("gen_population", population, 5);
    check("gen_painted_count", gp_count - gp0, 1);
    check("gen_painted_timing", gp_cyc - last_wr_cyc, 2);
    check("gen_queue", exp_q.size(), 0);

    // 36 strobes of which 4 changed
    w0 = wr_count;
    gp0 = gp_count;
    alive_cnt = 0;
    for (int i = 0; i < 36; i++) begin
      alv = $urandom_range(0, 1);
      alive_cnt += alv;
      drive_cell(i % 6, i / 6, alv, (i == 3 || i == 10 || i == 22 || i == 35), i == 35, 1'b1);
      repeat (18) tick();
    end
    wait_idle(500, "chg");
`ifdef LIFE_PAINTER_CHANGED_ONLY_EN
    check("chg_nwrites", wr_count - w0, 4 * 16);
`else
    check("chg_nwrites", wr_count - w0, 36 * 16);
`endif
    check("chg_population", population, alive_cnt);
    check("chg_painted_count", gp_count - gp0, 1);

    // Randomized generations with random framebuffer backpressure
    rnd_busy = 1;
    for (int g = 0; g < 6; g++) begin
      gp0 = gp_count;
      alive_cnt = 0;
      ncell = $urandom_range(1, FIFO_DEPTH);
      for (int i = 0; i < ncell; i++) begin
        x = int'($urandom_range(0, COLS + 8)) - 3;
        y = int'($urandom_range(0, ROWS + 6)) - 3;
        alv = $urandom_range(0, 1);
        alive_cnt += alv;
        drive_cell(x, y, alv, $urandom_range(0, 1), i == ncell - 1, 1'b1);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_idle(3000, "rnd");
      check("rnd_population", population, alive_cnt);
      check("rnd_painted_count", gp_count - gp0, 1);
      check("rnd_queue", exp_q.size(), 0);
    end
    rnd_busy = 0;
    tick();
    check("rnd_overflow", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
